// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: FSM states, screen geometry
// and score constants.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int SCREEN_WIDTH      = 640;
  localparam int SCREEN_HEIGHT     = 480;
  localparam int PADDLE_SIZE       = 64;
  localparam int BALL_SIZE         = 8;
  localparam int WIN_SCORE_DEFAULT = 9;
  localparam int SCORE_W           = 4;

  // Scores stop at their maximum value instead of rolling over to zero.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Player/ball-datapath signals of the match controller. The master side is the
// controller itself; the slave side is the game datapath and button logic.
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic               btn_start;
  logic               miss_left;
  logic               miss_right;
  logic               serve;
  logic               serve_dir;
  logic               move_tick;
  logic               run;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;
  logic               winner;

  modport master (
    input  btn_start, miss_left, miss_right,
    output serve, serve_dir, move_tick, run, score1, score2, game_over, winner
  );

  modport slave (
    output btn_start, miss_left, miss_right,
    input  serve, serve_dir, move_tick, run, score1, score2, game_over, winner
  );

endinterface

// File: rtl/pong_tick_gen.sv
// Free-running move-tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap.
module pong_tick_gen #(
  parameter int TICK_DIV = 131072
) (
  input  logic clk,
  input  logic locked,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge locked) begin
    if (!locked) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: start-button conditioning, move-tick generation and the
// serve/play/score FSM. Define PONG_AUTO_SERVE_EN to serve automatically after
// SERVE_DELAY move ticks instead of waiting for the start button.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 131072,
  parameter int WIN_SCORE   = WIN_SCORE_DEFAULT,
  parameter int SERVE_DELAY = 64
) (
  input  logic                  clk,
  input  logic                  locked,
  pong_match_ctrl_if.master     bus,
  output state_t                state_dbg
);

  state_t state;
  logic   sync1, sync2, edge_q;
  logic   start_evt;
  logic   tick;
  logic   win_now;

  // btn_start is asynchronous: two flops to settle it, a third to find the rising edge.
  always_ff @(posedge clk or negedge locked) begin
    if (!locked) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= bus.btn_start;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign start_evt = sync2 & ~edge_q;

  pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .locked (locked),
    .tick   (tick)
  );

  // In POINT, serve_dir already names the player who just scored (1 = player 1).
  assign win_now = bus.serve_dir ? (bus.score1 == SCORE_W'(WIN_SCORE))
                                 : (bus.score2 == SCORE_W'(WIN_SCORE));

`ifdef PONG_AUTO_SERVE_EN
  localparam int DW = $clog2(SERVE_DELAY + 1);
  logic [DW-1:0] delay_cnt;
`endif

  always_ff @(posedge clk or negedge locked) begin
    if (!locked) begin
      state         <= IDLE;
      bus.score1    <= '0;
      bus.score2    <= '0;
      bus.serve     <= 1'b0;
      bus.serve_dir <= 1'b0;
      bus.move_tick <= 1'b0;
      bus.run       <= 1'b0;
      bus.game_over <= 1'b0;
      bus.winner    <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
      delay_cnt     <= '0;
`endif
    end else begin
      bus.serve     <= 1'b0;
      bus.move_tick <= tick && (state == PLAY);
`ifdef PONG_AUTO_SERVE_EN
      // Delay counter restarts on every SERVE entry.
      if (state != SERVE) delay_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          bus.run <= 1'b0;
          if (start_evt) begin
            bus.score1    <= '0;
            bus.score2    <= '0;
            bus.serve_dir <= 1'b1;
            state         <= SERVE;
          end
        end
        SERVE: begin
          bus.run <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
          if (tick) begin
            if (delay_cnt == DW'(SERVE_DELAY - 1)) begin
              bus.serve <= 1'b1;
              bus.run   <= 1'b1;
              state     <= PLAY;
            end else begin
              delay_cnt <= delay_cnt + 1'b1;
            end
          end
`else
          if (start_evt) begin
            bus.serve <= 1'b1;
            bus.run   <= 1'b1;
            state     <= PLAY;
          end
`endif
        end
        PLAY: begin
          bus.run <= 1'b1;
          if (bus.miss_left) begin
            bus.score2    <= score_inc(bus.score2);
            bus.serve_dir <= 1'b0;
            bus.run       <= 1'b0;
            state         <= POINT;
          end else if (bus.miss_right) begin
            bus.score1    <= score_inc(bus.score1);
            bus.serve_dir <= 1'b1;
            bus.run       <= 1'b0;
            state         <= POINT;
          end
        end
        POINT: begin
          bus.run <= 1'b0;
          if (win_now) begin
            bus.game_over <= 1'b1;
            bus.winner    <= ~bus.serve_dir;
            state         <= OVER;
          end else begin
            state <= SERVE;
          end
        end
        OVER: begin
          bus.run <= 1'b0;
          if (start_evt) begin
            bus.score1    <= '0;
            bus.score2    <= '0;
            bus.game_over <= 1'b0;
            bus.serve_dir <= 1'b1;
            state         <= SERVE;
          end
        end
        default: begin
          bus.run <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed plus randomized bench for pong_match_ctrl with TICK_DIV=4, WIN_SCORE=3,
// SERVE_DELAY=2; match rules are tracked by a score-level model.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  localparam int TDIV = 4;
  localparam int WIN  = 3;
  localparam int SDLY = 2;

  logic   clk = 1'b0;
  logic   locked = 1'b0;
  state_t state_dbg;
  int     n_vec = 0;
  int     n_err = 0;

  // Score-level model of the match.
  int m_s1, m_s2, m_dir, m_over, m_win;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(.TICK_DIV(TDIV), .WIN_SCORE(WIN), .SERVE_DELAY(SDLY)) dut (
    .clk       (clk),
    .locked    (locked),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_s1"}, 32'(bus.score1), 32'(m_s1));
    check({tag, "_s2"}, 32'(bus.score2), 32'(m_s2));
    check({tag, "_over"}, 32'(bus.game_over), 32'(m_over));
  endtask

  // Start button pulse; the start event lands on the third edge after the rise.
  task automatic press_start();
    bus.btn_start = 1'b0;
    step(3);
    bus.btn_start = 1'b1;
    step(3);
    bus.btn_start = 1'b0;
  endtask

  // Called right after SERVE is entered; returns one cycle into PLAY.
  task automatic do_serve();
`ifdef PONG_AUTO_SERVE_EN
    int k;
    bus.btn_start = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step(1);
      if (bus.serve) break;
    end
    bus.btn_start = 1'b0;
    check("auto_serve_seen", 32'(bus.serve), 32'd1);
    // Second observed tick after entry: between one and two tick periods away.
    check("auto_serve_window", 32'(k >= (SDLY-1)*TDIV+1 && k <= SDLY*TDIV), 32'd1);
`else
    press_start();
    check("serve_pulse", 32'(bus.serve), 32'd1);
`endif
    check("serve_run", 32'(bus.run), 32'd1);
    check("serve_state", 32'(state_dbg), 32'(PLAY));
    step(1);
    check("serve_one_cycle", 32'(bus.serve), 32'd0);
  endtask

  // kind: 0 = miss_left, 1 = miss_right, 2 = both at once.
  task automatic do_point(input int kind);
    bus.miss_left  = (kind != 1);
    bus.miss_right = (kind != 0);
    step(1);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    if (kind != 1) begin
      m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
      m_dir = 0;
    end else begin
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
      m_dir = 1;
    end
    check("point_state", 32'(state_dbg), 32'(POINT));
    check("point_dir", 32'(bus.serve_dir), 32'(m_dir));
    check("point_run", 32'(bus.run), 32'd0);
    check_scores("point");
    step(1);
    if (m_s1 == WIN || m_s2 == WIN) begin
      m_over = 1;
      m_win  = (m_s2 == WIN) ? 1 : 0;
      check("over_state", 32'(state_dbg), 32'(OVER));
      check("over_winner", 32'(bus.winner), 32'(m_win));
    end else begin
      check("after_point_state", 32'(state_dbg), 32'(SERVE));
    end
    check("after_point_run", 32'(bus.run), 32'd0);
    check_scores("after_point");
  endtask

  task automatic restart_from_over();
    press_start();
    m_s1 = 0; m_s2 = 0; m_over = 0; m_dir = 1;
    check("restart_state", 32'(state_dbg), 32'(SERVE));
    check("restart_dir", 32'(bus.serve_dir), 32'd1);
    check_scores("restart");
  endtask

  initial begin
    int first, last, cnt;
    bus.btn_start  = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    m_s1 = 0; m_s2 = 0; m_dir = 0; m_over = 0; m_win = 0;

    // Reset held for 5 cycles.
    step(5);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    locked = 1'b1;
    step(1);
    check("rst_outs", {bus.serve, bus.serve_dir, bus.move_tick, bus.run,
                       bus.score1, bus.score2, bus.game_over, bus.winner}, 32'd0);
    check("rst_idle", 32'(state_dbg), 32'(IDLE));
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.move_tick || bus.serve) cnt++;
    end
    check("idle_no_tick", 32'(cnt), 32'd0);

    // Start from IDLE: SERVE three edges after the rise.
    bus.btn_start = 1'b1;
    step(2);
    check("start_not_yet", 32'(state_dbg), 32'(IDLE));
    step(1);
    check("start_serve", 32'(state_dbg), 32'(SERVE));
    check("start_dir", 32'(bus.serve_dir), 32'd1);
    m_dir = 1;
    check_scores("start");
`ifdef PONG_AUTO_SERVE_EN
    do_serve();
`else
    step(7);
    bus.btn_start = 1'b0;
    check("hold_still_serve", 32'(state_dbg), 32'(SERVE));
    check("hold_no_run", 32'(bus.run), 32'd0);
    do_serve();
`endif

    // Move tick cadence in PLAY.
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (bus.move_tick) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    check("tick_count", 32'(cnt), 32'd4);
    check("tick_span", 32'(last - first), 32'd12);

    // Directed scoring: left miss, simultaneous miss, then player 1 wins.
    do_point(0);
    do_serve();
    do_point(2);
    for (int i = 0; i < 3; i++) begin
      do_serve();
      do_point(1);
    end
    check("win_over", 32'(bus.game_over), 32'd1);
    check("win_s1", 32'(bus.score1), 32'(WIN));

    // Misses outside PLAY are ignored.
    bus.miss_left = 1'b1; bus.miss_right = 1'b1;
    step(3);
    bus.miss_left = 1'b0; bus.miss_right = 1'b0;
    step(1);
    check_scores("over_ignore");
    check("over_run", 32'(bus.run), 32'd0);
    restart_from_over();

    // Randomized matches against the score model.
    for (int g = 0; g < 4; g++) begin
      while (!m_over) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.miss_left  = 1'($urandom_range(0, 1));
          bus.miss_right = 1'($urandom_range(0, 1));
          step(1);
          bus.miss_left = 1'b0; bus.miss_right = 1'b0;
          check("serve_ignore_state", 32'(state_dbg), 32'(SERVE));
          check_scores("serve_ignore");
        end
        do_serve();
        step($urandom_range(0, 6));
        check("play_run", 32'(bus.run), 32'd1);
        do_point($urandom_range(0, 2));
      end
      restart_from_over();
    end

    // Reset in the middle of a rally discards the score and emits no serve.
    do_serve();
    do_point(0);
    do_serve();
    locked = 1'b0;
    #1;
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_s2", 32'(bus.score2), 32'd0);
    check("midrst_run", 32'(bus.run), 32'd0);
    step(2);
    locked = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.serve || bus.run) cnt++;
    end
    check("midrst_no_serve", 32'(cnt), 32'd0);
    check("midrst_idle", 32'(state_dbg), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
